// File: rtl/vga_pkg.sv
// Shared VGA timing types and the default 640x480@60 timing set.
package vga_pkg;

  typedef struct packed {
    int visible;
    int fp;
    int sync;
    int bp;
  } timing_t;

  localparam timing_t VGA_640X480_H = '{visible: 640, fp: 16, sync: 96, bp: 48};
  localparam timing_t VGA_640X480_V = '{visible: 480, fp: 10, sync: 2,  bp: 33};

  function automatic int timing_total(timing_t t);
    return t.visible + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping axis counter; wrap flags the enabled step that returns to 0.
module vga_axis_counter #(
  parameter int TOTAL = 800,
  parameter int W     = 10
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;

  assign o_cnt  = r_cnt;
  assign o_wrap = i_en && (r_cnt == W'(TOTAL - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset)     r_cnt <= '0;
    else if (o_wrap) r_cnt <= '0;
    else if (i_en)   r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: h/v counters, decoded sync/DE/coords, line/frame
// strobes and a frame counter, all presented one clk after the counters.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_640X480_H.visible,
  parameter int H_FP      = VGA_640X480_H.fp,
  parameter int H_SYNC    = VGA_640X480_H.sync,
  parameter int H_BP      = VGA_640X480_H.bp,
  parameter int V_VISIBLE = VGA_640X480_V.visible,
  parameter int V_FP      = VGA_640X480_V.fp,
  parameter int V_SYNC    = VGA_640X480_V.sync,
  parameter int V_BP      = VGA_640X480_V.bp,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int CNT_W     = 10,
  parameter int FRAME_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_pixel_tick,
  output logic               o_h_sync,
  output logic               o_v_sync,
  output logic               o_de,
  output logic [CNT_W-1:0]   o_pixel_x,
  output logic [CNT_W-1:0]   o_pixel_y,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic [FRAME_W-1:0] o_frame_cnt
);

  localparam timing_t H_T = '{visible: H_VISIBLE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam timing_t V_T = '{visible: V_VISIBLE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int H_TOTAL  = timing_total(H_T);
  localparam int V_TOTAL  = timing_total(V_T);

  logic [CNT_W-1:0]   w_h_cnt, w_v_cnt;
  logic               w_h_wrap, w_v_wrap;
  logic               w_hs_act, w_vs_act, w_de;
  int                 w_h, w_v;
  logic [FRAME_W-1:0] r_frame;
  logic               r_tick_d;

  vga_axis_counter #(.TOTAL(H_TOTAL), .W(CNT_W)) u_h_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (i_pixel_tick),
    .o_cnt   (w_h_cnt),
    .o_wrap  (w_h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .W(CNT_W)) u_v_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_h_wrap),
    .o_cnt   (w_v_cnt),
    .o_wrap  (w_v_wrap)
  );

  assign w_h      = int'(w_h_cnt);
  assign w_v      = int'(w_v_cnt);
  assign w_hs_act = (w_h >= H_VISIBLE + H_FP) && (w_h < H_VISIBLE + H_FP + H_SYNC);
  assign w_vs_act = (w_v >= V_VISIBLE + V_FP) && (w_v < V_VISIBLE + V_FP + V_SYNC);
  assign w_de     = (w_h < H_VISIBLE) && (w_v < V_VISIBLE);

  // r_tick_d marks that the counters just stepped, so strobes fire only on
  // the first presentation of a new state and never after reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frame  <= '0;
      r_tick_d <= 1'b0;
    end else begin
      r_tick_d <= i_pixel_tick;
      if (w_v_wrap) r_frame <= r_frame + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_h_sync      <= ~H_POL;
      o_v_sync      <= ~V_POL;
      o_de          <= 1'b0;
      o_pixel_x     <= '0;
      o_pixel_y     <= '0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      o_h_sync      <= w_hs_act ? H_POL : ~H_POL;
      o_v_sync      <= w_vs_act ? V_POL : ~V_POL;
      o_de          <= w_de;
      o_pixel_x     <= w_de ? w_h_cnt : '0;
      o_pixel_y     <= w_de ? w_v_cnt : '0;
      o_line_start  <= r_tick_d && (w_h_cnt == '0);
      o_frame_start <= r_tick_d && (w_h_cnt == '0) && (w_v_cnt == '0);
      o_frame_cnt   <= r_frame;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a tick-count reference model predicts every presented
// output state of two configurations (active-low/8-bit, active-high/2-bit).
module tb_vga_timing_gen;

  localparam int HV = 8, HF = 2, HS = 2, HB = 2;
  localparam int VV = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int CW = 10;

  typedef struct packed {
    logic          hs, vs, de;
    logic [CW-1:0] px, py;
    logic          ls, fs;
    logic [7:0]    fc;
  } out_t;

  typedef struct packed { out_t e0; out_t e1; } exp_t;

  logic clk = 1'b0, reset = 1'b1, tick = 1'b0;
  always #5 clk = ~clk;

  logic          hs0, vs0, de0, ls0, fs0, hs1, vs1, de1, ls1, fs1;
  logic [CW-1:0] px0, py0, px1, py1;
  logic [7:0]    fc0;
  logic [1:0]    fc1;

  vga_timing_gen #(.H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .CNT_W(CW), .FRAME_W(8)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_pixel_tick(tick),
    .o_h_sync(hs0), .o_v_sync(vs0), .o_de(de0), .o_pixel_x(px0), .o_pixel_y(py0),
    .o_line_start(ls0), .o_frame_start(fs0), .o_frame_cnt(fc0));

  vga_timing_gen #(.H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(CW), .FRAME_W(2)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_pixel_tick(tick),
    .o_h_sync(hs1), .o_v_sync(vs1), .o_de(de1), .o_pixel_x(px1), .o_pixel_y(py1),
    .o_line_start(ls1), .o_frame_start(fs1), .o_frame_cnt(fc1));

  exp_t q[$];
  int   n_checks = 0, n_errors = 0, cyc = 0;
  int   n = 0;          // pixel ticks taken since the last reset
  bit   prev_tick = 0;  // previous edge stepped the raster

  function automatic out_t ref_rst(bit pol);
    out_t o = '0;
    o.hs = !pol;
    o.vs = !pol;
    return o;
  endfunction

  // Raster position derived purely from the number of ticks since reset.
  function automatic out_t ref_state(int cnt, bit stepped, bit pol, int fw);
    out_t o;
    int h = cnt % HT;
    int v = (cnt / HT) % VT;
    int f = cnt / (HT * VT);
    bit de = (h < HV) && (v < VV);
    o.hs = ((h >= HV + HF) && (h < HV + HF + HS)) ? pol : !pol;
    o.vs = ((v >= VV + VF) && (v < VV + VF + VS)) ? pol : !pol;
    o.de = de;
    o.px = de ? CW'(h) : '0;
    o.py = de ? CW'(v) : '0;
    o.ls = stepped && (h == 0);
    o.fs = stepped && (h == 0) && (v == 0);
    o.fc = 8'(f % (1 << fw));
    return o;
  endfunction

  task automatic step(input bit r, input bit t);
    exp_t e;
    reset = r;
    tick  = t;
    if (r) begin
      e.e0 = ref_rst(1'b0);
      e.e1 = ref_rst(1'b1);
      n = 0;
      prev_tick = 0;
    end else begin
      e.e0 = ref_state(n, prev_tick, 1'b0, 8);
      e.e1 = ref_state(n, prev_tick, 1'b1, 2);
      if (t) n++;
      prev_tick = t;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (q.size() > 0) begin
      exp_t e;
      out_t a0, a1;
      e  = q.pop_front();
      a0 = '{hs0, vs0, de0, px0, py0, ls0, fs0, fc0};
      a1 = '{hs1, vs1, de1, px1, py1, ls1, fs1, {6'd0, fc1}};
      n_checks += 2;
      if (a0 !== e.e0) begin
        n_errors++;
        $display("FAIL lowpol_state cyc=%0d got=%h want=%h", cyc, a0, e.e0);
      end
      if (a1 !== e.e1) begin
        n_errors++;
        $display("FAIL highpol_state cyc=%0d got=%h want=%h", cyc, a1, e.e1);
      end
    end
  end

  initial begin
    int guard;
    repeat (3) step(1'b1, 1'b0);
    // continuous ticks for a bit over two frames
    repeat (2 * HT * VT + 20) step(1'b0, 1'b1);
    // one tick every 4th clk for just over one frame
    for (int i = 0; i < 4 * HT * VT + 16; i++) step(1'b0, (i % 4) == 3);
    // random tick density
    repeat (1200) step(1'b0, 1'($urandom_range(0, 1)));
    // reset mid-frame at h=5, v=3 with a tick on the same edge
    guard = 0;
    while (!((n % HT) == 5 && ((n / HT) % VT) == 3) && guard < 2 * HT * VT) begin
      step(1'b0, 1'b1);
      guard++;
    end
    if (guard >= 2 * HT * VT) begin
      n_errors++;
      $display("FAIL midframe_target not reached within %0d steps", guard);
    end
    step(1'b1, 1'b1);
    // five full frames to walk the 2-bit frame counter through its wrap
    repeat (5 * HT * VT + 10) step(1'b0, 1'b1);
    // random ticks with occasional resets
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 199) == 0, 1'($urandom_range(0, 2) != 0));
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
